// File: rtl/rtc_ad_bus_port.sv
// Multiplexed address/data bus port for the RTC: address phase, then write or read data phase,
// with programmable strobe pulse, hold and turnaround times. All pin-side outputs are registered.
module rtc_ad_bus_port #(
  parameter int WIDTH   = 8,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             rw,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             cs_n,
  output logic             ad_n,
  output logic             wr_n,
  output logic             rd_n,
  inout  wire  [WIDTH-1:0] ad_bus
);

  localparam int MAXP = (T_PULSE > T_HOLD) ? ((T_PULSE > T_TURN) ? T_PULSE : T_TURN)
                                           : ((T_HOLD > T_TURN) ? T_HOLD : T_TURN);
  localparam int CW = $clog2(MAXP) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_WDATA, S_WHOLD, S_TURN, S_RDATA, S_RHOLD, S_END
  } state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             oe;
  logic [WIDTH-1:0] drive;
  logic             rw_q;
  logic [WIDTH-1:0] wdata_q;
  logic             in_txn_nxt, oe_nxt;

  // Counter holds remaining cycles minus one, so a state ends when it reads zero.
  function automatic logic [CW-1:0] load_val(input state_t s);
    case (s)
      S_ADDR, S_WDATA, S_RDATA: load_val = CW'(T_PULSE - 1);
      S_AHOLD, S_WHOLD, S_RHOLD: load_val = CW'(T_HOLD - 1);
      S_TURN:                    load_val = CW'(T_TURN - 1);
      default:                   load_val = '0;
    endcase
  endfunction

  assign ad_bus = oe ? drive : 'z;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (req)        nxt = S_ADDR;
      S_ADDR:  if (cnt == '0)  nxt = S_AHOLD;
      S_AHOLD: if (cnt == '0)  nxt = rw_q ? S_TURN : S_WDATA;
      S_WDATA: if (cnt == '0)  nxt = S_WHOLD;
      S_WHOLD: if (cnt == '0)  nxt = S_END;
      S_TURN:  if (cnt == '0)  nxt = S_RDATA;
      S_RDATA: if (cnt == '0)  nxt = S_RHOLD;
      S_RHOLD: if (cnt == '0)  nxt = S_END;
      S_END:                   nxt = S_IDLE;
      default:                 nxt = S_IDLE;
    endcase
    cnt_nxt    = (nxt != state) ? load_val(nxt) : cnt - CW'(1);
    in_txn_nxt = nxt inside {S_ADDR, S_AHOLD, S_WDATA, S_WHOLD, S_TURN, S_RDATA, S_RHOLD};
    oe_nxt     = nxt inside {S_ADDR, S_AHOLD, S_WDATA, S_WHOLD};
  end

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cs_n    <= 1'b1;
      ad_n    <= 1'b1;
      wr_n    <= 1'b1;
      rd_n    <= 1'b1;
      oe      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      drive   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      cs_n  <= !in_txn_nxt;
      busy  <= in_txn_nxt;
      ad_n  <= (nxt != S_ADDR);
      wr_n  <= (nxt != S_WDATA);
      rd_n  <= (nxt != S_RDATA);
      oe    <= oe_nxt;
      done  <= (nxt == S_END);
      if (state == S_IDLE && req) begin
        rw_q    <= rw;
        wdata_q <= wdata;
        drive   <= addr;
      end
      if (state == S_AHOLD && nxt == S_WDATA)
        drive <= wdata_q;
      // Sample at the edge closing the last RD# low cycle.
      if (state == S_RDATA && cnt == '0)
        rdata <= ad_bus;
    end
  end

endmodule

// File: tb/tb_rtc_ad_bus_port.sv
// Bench for rtc_ad_bus_port: cycle-index reference model checked every cycle, a directed
// transaction table, multi-cycle corner sequences, random traffic and a 16-bit fast instance.
module tb_rtc_ad_bus_port;
  localparam int W = 8, TP = 4, TH = 2, TT = 1;
  localparam int DW = 2*TP + 2*TH + 1;
  localparam int DR = DW + TT;
  localparam int WR_LO = TP + TH + 1, WR_HI = 2*TP + TH;
  localparam int RD_LO = TP + TH + TT + 1, RD_HI = 2*TP + TH + TT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req, rw;
  logic [W-1:0] addr, wdata, rdval_in, rdata;
  logic busy, done, cs_n, ad_n, wr_n, rd_n;
  wire  [W-1:0] ad_bus;

  logic req16, rw16, busy16, done16, cs_n16, ad_n16, wr_n16, rd_n16;
  logic [15:0] addr16, wdata16, rdata16;
  wire  [15:0] ad_bus16;

  // Reference model: k = cycle index within the current transaction (0 = idle).
  int k, m_d;
  logic m_rw, m_act, m_oe;
  logic [W-1:0] m_addr, m_wdata, m_rdval, exp_rdata;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  assign ad_bus   = !rd_n   ? m_rdval  : 'z;
  assign ad_bus16 = !rd_n16 ? 16'hC3D2 : 'z;

  rtc_ad_bus_port #(.WIDTH(W), .T_PULSE(TP), .T_HOLD(TH), .T_TURN(TT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .cs_n(cs_n), .ad_n(ad_n),
    .wr_n(wr_n), .rd_n(rd_n), .ad_bus(ad_bus));

  rtc_ad_bus_port #(.WIDTH(16), .T_PULSE(1), .T_HOLD(1), .T_TURN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .rw(rw16), .addr(addr16), .wdata(wdata16),
    .busy(busy16), .done(done16), .rdata(rdata16), .cs_n(cs_n16), .ad_n(ad_n16),
    .wr_n(wr_n16), .rd_n(rd_n16), .ad_bus(ad_bus16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      exp_rdata = '0;
    end else if (k == 0) begin
      if (req) begin
        k = 1; m_rw = rw; m_addr = addr; m_wdata = wdata; m_rdval = rdval_in;
      end
    end else begin
      if (m_rw && k == RD_HI) exp_rdata = m_rdval;
      if (k == (m_rw ? DR : DW)) k = 0;
      else k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_d   = m_rw ? DR : DW;
      m_act = (k >= 1 && k < m_d);
      m_oe  = m_act && (!m_rw || k <= TP + TH);
      chk("cs_n", 32'(cs_n), 32'(!m_act));
      chk("busy", 32'(busy), 32'(m_act));
      chk("done", 32'(done), 32'(k != 0 && k == m_d));
      chk("ad_n", 32'(ad_n), 32'(!(k >= 1 && k <= TP)));
      chk("wr_n", 32'(wr_n), 32'(!(k != 0 && !m_rw && k >= WR_LO && k <= WR_HI)));
      chk("rd_n", 32'(rd_n), 32'(!(k != 0 && m_rw && k >= RD_LO && k <= RD_HI)));
      chk("bus_oe", 32'(dut.oe), 32'(m_oe));
      if (m_oe) chk("ad_bus", 32'(ad_bus), 32'((k <= TP + TH) ? m_addr : m_wdata));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
    end
  end

  task automatic wait_accept(output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (k != 1 && n < 40);
    ok = (k == 1);
    if (!ok) begin errors++; $display("FAIL accept_timeout: got no acceptance expected one within 40 cycles"); end
  endtask

  task automatic run_txn(input logic r, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] rv, output int dc);
    bit ok;
    rw = r; addr = a; wdata = d; rdval_in = rv; req = 1'b1;
    dc = -1;
    wait_accept(ok);
    req = 1'b0;
    if (ok) begin
      for (int c = 1; c <= 40; c++) begin
        if (done) begin dc = c; break; end
        @(negedge clk);
      end
    end
  endtask

  typedef struct { logic rw; logic [W-1:0] a, d, rv; int dc; logic [W-1:0] rd; } vec_t;
  vec_t tbl[6];

  initial begin
    int dc, c1, c2, nd;
    bit ok;
    tbl[0] = '{1'b0, 8'h21, 8'h45, 8'h00, 13, 8'h00};
    tbl[1] = '{1'b1, 8'h02, 8'h00, 8'hA5, 14, 8'hA5};
    tbl[2] = '{1'b0, 8'hFF, 8'h00, 8'h11, 13, 8'hA5};
    tbl[3] = '{1'b1, 8'h80, 8'hEE, 8'h3C, 14, 8'h3C};
    tbl[4] = '{1'b1, 8'h00, 8'h00, 8'h5A, 14, 8'h5A};
    tbl[5] = '{1'b0, 8'h00, 8'hFF, 8'h99, 13, 8'h5A};

    rst_n = 0; req = 0; rw = 0; addr = '0; wdata = '0; rdval_in = '0;
    req16 = 0; rw16 = 0; addr16 = '0; wdata16 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      run_txn(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].rv, dc);
      chk("done_cycle", 32'(dc), 32'(tbl[i].dc));
      chk("rdata_at_done", 32'(rdata), 32'(tbl[i].rd));
    end

    // req pulsed in cycle 5 of a write must be ignored
    rw = 0; addr = 8'h11; wdata = 8'h22; req = 1;
    wait_accept(ok);
    req = 0;
    repeat (4) @(negedge clk);
    rw = 1; addr = 8'h33; rdval_in = 8'h77; req = 1;
    @(negedge clk);
    req = 0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin if (done) nd++; @(negedge clk); end
    chk("ignored_req_done_count", 32'(nd), 32'd1);
    chk("ignored_req_rdata", 32'(rdata), 32'h5A);

    // reset in cycle 8 of a write
    rw = 0; addr = 8'h44; wdata = 8'h55; req = 1;
    wait_accept(ok);
    req = 0;
    repeat (7) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_wr_n", 32'(wr_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bus_released", 32'(dut.oe), 32'd0);
    run_txn(1'b0, 8'h66, 8'h77, 8'h00, dc);
    chk("post_reset_done_cycle", 32'(dc), 32'd13);

    // req held high across two reads
    rw = 1; addr = 8'h02; rdval_in = 8'hC1; req = 1;
    wait_accept(ok);
    rdval_in = 8'hD2;
    c1 = -1; c2 = -1;
    for (int c = 1; c <= 60 && c2 < 0; c++) begin
      if (done && c1 < 0) begin c1 = c; chk("b2b_rdata1", 32'(rdata), 32'hC1); end
      if (c1 >= 0 && c > c1 && !ad_n) begin c2 = c; req = 0; end
      else @(negedge clk);
    end
    req = 0;
    chk("b2b_turnaround", 32'(c2 - c1), 32'd2);
    dc = -1;
    for (int c = 0; c < 40; c++) begin if (done) begin dc = c; break; end @(negedge clk); end
    chk("b2b_second_done_seen", 32'(dc >= 0), 32'd1);
    chk("b2b_rdata2", 32'(rdata), 32'hD2);

    // random traffic, occasional resets
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 63) != 0);
      req      = ($urandom_range(0, 3) == 0);
      rw       = 1'($urandom);
      addr     = W'($urandom);
      wdata    = W'($urandom);
      rdval_in = W'($urandom);
    end
    @(negedge clk);
    rst_n = 1; req = 0;
    repeat (20) @(negedge clk);

    // 16-bit instance, minimum timing: write then read
    rw16 = 0; addr16 = 16'h1234; wdata16 = 16'hBEEF; req16 = 1;
    @(negedge clk);
    req16 = 0;
    dc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin chk("w16_ad_n", 32'(ad_n16), 32'd0); chk("w16_addr", 32'(ad_bus16), 32'h1234); end
      if (c == 3) begin chk("w16_wr_n", 32'(wr_n16), 32'd0); chk("w16_wdata", 32'(ad_bus16), 32'hBEEF); end
      if (done16 && dc < 0) dc = c;
      @(negedge clk);
    end
    chk("w16_done_cycle", 32'(dc), 32'd5);
    rw16 = 1; addr16 = 16'h0055; req16 = 1;
    @(negedge clk);
    req16 = 0;
    dc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) chk("r16_rd_n", 32'(rd_n16), 32'd0);
      if (done16 && dc < 0) begin dc = c; chk("r16_rdata", 32'(rdata16), 32'hC3D2); end
      @(negedge clk);
    end
    chk("r16_done_cycle", 32'(dc), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
